// File: rtl/dunit_pkg.sv
// dunit_pkg: shared definitions for the debug-unit controller.
// Contents: controller state enumeration, UART command byte codes and the
// HALT instruction word that terminates a program load.
package dunit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_PRE_RUN   = 3'd2,
        ST_RUN       = 3'd3,
        ST_PRE_STEP  = 3'd4,
        ST_STEP_WAIT = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NEXT  = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_ABORT = 8'h41;  // 'A'

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/dunit_word_asm.sv
// dunit_word_asm: assembles UART bytes MSB-first into instruction words.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_clear          restart assembly (discard any partial word)
//   i_en             accept bytes only while enabled
//   i_byte, i_valid  received byte and its one-cycle strobe
//   o_word           last completed word (held until the next one completes)
//   o_ready          one-cycle pulse in the cycle after the 4th byte
module dunit_word_asm #(
    parameter int unsigned NB_REG  = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic [NB_BYTE-1:0] i_byte,
    input  logic               i_valid,
    output logic [NB_REG-1:0]  o_word,
    output logic               o_ready
);

    localparam int unsigned NB_SR = NB_REG - NB_BYTE;

    logic [NB_SR-1:0] sr_q;
    logic [1:0]       cnt_q;

    // Shift in the first three bytes; the fourth completes the word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            o_word  <= '0;
            o_ready <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            if (i_clear) begin
                sr_q  <= '0;
                cnt_q <= '0;
            end else if (i_en && i_valid) begin
                if (cnt_q == 2'd3) begin
                    o_word  <= {sr_q, i_byte};
                    o_ready <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sr_q  <= {sr_q[NB_SR-NB_BYTE-1:0], i_byte};
                    cnt_q <= cnt_q + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/dunit_ctrl.sv
// dunit_ctrl: debug-unit controller for the MIPS pipeline.
// Loads program words received over UART into instruction memory and then
// sequences execution (continuous or single-step) via the pipeline clock enable.
// Optional feature: define DUNIT_ABORT_EN to let 'A' abort RUN/STEP_WAIT to IDLE.
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_rx_data, i_rx_valid UART byte and one-cycle valid strobe
//   i_halt                HALT instruction is in WB
//   o_dunit_clk_en        pipeline clock enable (combinational on i_halt)
//   o_dunit_w_en/addr/data instruction-memory debug write port
//   o_pipe_reset          one-cycle pipeline reset before execution
//   o_done                program halted
//   o_load_ovf            sticky: memory filled before a HALT word arrived
module dunit_ctrl
    import dunit_pkg::*;
#(
    parameter int unsigned NB_REG   = 32,
    parameter int unsigned NB_WIDHT = 9,
    parameter int unsigned NB_BYTE  = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_halt,
    output logic                o_dunit_clk_en,
    output logic                o_dunit_w_en,
    output logic [NB_WIDHT-1:0] o_dunit_addr,
    output logic [NB_REG-1:0]   o_dunit_data,
    output logic                o_pipe_reset,
    output logic                o_done,
    output logic                o_load_ovf
);

    localparam logic [NB_WIDHT-1:0] ADDR_STEP = NB_WIDHT'(4);
    localparam logic [NB_WIDHT-1:0] LAST_ADDR = NB_WIDHT'((1 << NB_WIDHT) - 4);

    state_e                state_q, state_d;
    logic [NB_WIDHT-1:0]   addr_q, addr_d;
    logic                  ovf_q, ovf_d;
    logic                  step_q, step_d;
    logic                  asm_clear_c;

    dunit_word_asm #(
        .NB_REG  (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_word_asm (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (asm_clear_c),
        .i_en    (state_q == ST_LOAD),
        .i_byte  (i_rx_data),
        .i_valid (i_rx_valid),
        .o_word  (o_dunit_data),
        .o_ready (o_dunit_w_en)
    );

    // State and control registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
            step_q  <= step_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ovf_d       = ovf_q;
        step_d      = 1'b0;
        asm_clear_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d     = ST_LOAD;
                        addr_d      = '0;
                        ovf_d       = 1'b0;
                        asm_clear_c = 1'b1;
                    end else if (i_rx_data == CMD_CONT) begin
                        state_d = ST_PRE_RUN;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_d = ST_PRE_STEP;
                    end
                end
            end
            ST_LOAD: begin
                // The write happens this cycle; decide whether the load ends.
                if (o_dunit_w_en) begin
                    addr_d = addr_q + ADDR_STEP;
                    if (o_dunit_data == HALT_WORD) begin
                        state_d = ST_IDLE;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            ST_PRE_RUN:  state_d = ST_RUN;
            ST_PRE_STEP: state_d = ST_STEP_WAIT;
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_DONE;
                end
`ifdef DUNIT_ABORT_EN
                else if (i_rx_valid && (i_rx_data == CMD_ABORT)) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_STEP_WAIT: begin
                // Halt takes priority over a coincident step request.
                if (i_halt) begin
                    state_d = ST_DONE;
                end else if (i_rx_valid && (i_rx_data == CMD_NEXT)) begin
                    step_d = 1'b1;
                end
`ifdef DUNIT_ABORT_EN
                else if (i_rx_valid && (i_rx_data == CMD_ABORT)) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clock enable is gated by i_halt in the same cycle so nothing issues past HALT.
    assign o_dunit_clk_en = ((state_q == ST_RUN) || step_q) && !i_halt;
    assign o_dunit_addr   = addr_q;
    assign o_pipe_reset   = (state_q == ST_PRE_RUN) || (state_q == ST_PRE_STEP);
    assign o_done         = (state_q == ST_DONE);
    assign o_load_ovf     = ovf_q;

endmodule
